fp_mul_round_pack: RTL

Final stage of the single-precision floating-point multiplier: consumes the raw 48-bit mantissa product, the unnormalised biased exponent, the sign and the `float_type::type_of_float` classification from the product stage. It normalises, rounds to nearest-even, detects post-rounding overflow and underflow, and packs an IEEE-754 binary32 word. It is a 2-stage valid/ready pipeline with full backpressure and sticky exception flags.

---
 rtl/fp_mul_round_pack.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fp_mul_round_pack.sv
// Final stage of the binary32 multiplier: normalise, round-to-nearest-even, range check and pack.
// Two-stage valid/ready pipeline with full backpressure and sticky overflow/underflow flags.

package float_type;
  typedef enum logic [2:0] {
    VALID             = 3'd0,
    OVERFLOW          = 3'd1,
    UNDERFLOW         = 3'd2,
    NaN               = 3'd3,
    positive_infinity = 3'd4,
    negative_infinity = 3'd5
  } type_of_float;
endpackage

module fp_mul_round_pack
  import float_type::*;
#(
  parameter bit FLUSH_UNF = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [47:0]              in_mant,
  input  logic [9:0]               in_exp,
  input  logic                     in_sign,
  input  float_type::type_of_float in_class,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output float_type::type_of_float out_class,
  input  logic                     flags_clr,
  output logic                     flag_ovf,
  output logic                     flag_unf
);

  // Handshake: a beat moves on valid & ready; a stage loads when it is empty or its
  // successor is taking its current beat, so in_ready sees out_ready combinationally.
  logic s1_valid_q, s2_valid_q;
  logic s1_load, s2_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Stage 1 state
  logic [22:0]        s1_frac_q, s1_frac_d;
  logic               s1_guard_q, s1_guard_d;
  logic               s1_sticky_q, s1_sticky_d;
  logic signed [10:0] s1_e_q, s1_e_d;
  logic               s1_sign_q;
  type_of_float       s1_class_q;
  logic               s1_zero_q, s1_zero_d;

  always_comb begin
    s1_frac_d   = in_mant[45:23];
    s1_guard_d  = in_mant[22];
    s1_sticky_d = |in_mant[21:0];
    if (in_mant[47]) begin
      s1_frac_d   = in_mant[46:24];
      s1_guard_d  = in_mant[23];
      s1_sticky_d = |in_mant[22:0];
    end
    s1_e_d    = {in_exp[9], in_exp} + {10'd0, in_mant[47]};
    s1_zero_d = (in_mant == 48'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_frac_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_e_q      <= '0;
      s1_sign_q   <= 1'b0;
      s1_class_q  <= VALID;
      s1_zero_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_frac_q   <= s1_frac_d;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
        s1_e_q      <= s1_e_d;
        s1_sign_q   <= in_sign;
        s1_class_q  <= in_class;
        s1_zero_q   <= s1_zero_d;
      end
    end
  end

  // Stage 2: round, then pick the result by class priority
  logic               round_up;
  logic [23:0]        rnd_sum;
  logic signed [10:0] e_rnd;
  logic               ovf_hit, unf_hit;
  logic [31:0]        out_data_q, out_data_d;
  type_of_float       out_class_q, out_class_d;

  always_comb begin
    round_up = s1_guard_q && (s1_sticky_q || s1_frac_q[0]);
    rnd_sum  = {1'b0, s1_frac_q} + {23'd0, round_up};
    // A carry out of the fraction means the significand became 2.0: the fraction bits are already zero.
    e_rnd    = s1_e_q + {10'd0, rnd_sum[23]};
    ovf_hit  = (e_rnd >= 11'sd255);
    // Only the flush-to-zero behaviour is implemented; there is no subnormal packing.
    unf_hit  = FLUSH_UNF && (e_rnd <= 11'sd0);

    out_data_d  = {s1_sign_q, e_rnd[7:0], rnd_sum[22:0]};
    out_class_d = VALID;
    if (s1_class_q == NaN) begin
      out_data_d  = 32'h7FC0_0000;
      out_class_d = NaN;
    end else if (s1_class_q == positive_infinity) begin
      out_data_d  = 32'h7F80_0000;
      out_class_d = positive_infinity;
    end else if (s1_class_q == negative_infinity) begin
      out_data_d  = 32'hFF80_0000;
      out_class_d = negative_infinity;
    end else if (s1_class_q == OVERFLOW || ovf_hit) begin
      out_data_d  = {s1_sign_q, 8'hFF, 23'h0};
      out_class_d = OVERFLOW;
    end else if (s1_class_q == UNDERFLOW || unf_hit) begin
      out_data_d  = {s1_sign_q, 31'h0};
      out_class_d = UNDERFLOW;
    end else if (s1_zero_q) begin
      out_data_d  = {s1_sign_q, 31'h0};
      out_class_d = VALID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      out_data_q  <= 32'h0;
      out_class_q <= VALID;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= out_data_d;
        out_class_q <= out_class_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_class = out_class_q;

  // Sticky flags: a delivery in the same cycle as a clear keeps the flag set.
  logic flag_ovf_q, flag_ovf_d;
  logic flag_unf_q, flag_unf_d;
  logic out_fire;

  always_comb begin
    out_fire   = s2_valid_q && out_ready;
    flag_ovf_d = flags_clr ? 1'b0 : flag_ovf_q;
    flag_unf_d = flags_clr ? 1'b0 : flag_unf_q;
    if (out_fire && out_class_q == OVERFLOW)  flag_ovf_d = 1'b1;
    if (out_fire && out_class_q == UNDERFLOW) flag_unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_ovf_q <= 1'b0;
      flag_unf_q <= 1'b0;
    end else begin
      flag_ovf_q <= flag_ovf_d;
      flag_unf_q <= flag_unf_d;
    end
  end

  assign flag_ovf = flag_ovf_q;
  assign flag_unf = flag_unf_q;

endmodule
